// File: rtl/rx_pkg.sv
// Shared RX types and sizing helpers for the word assembler and its counter.
package rx_pkg;

   localparam int USB_BYTE_BITS = 8;
   localparam int MAX_WORD_BITS = 32;

   typedef struct packed {
      logic [MAX_WORD_BITS-1:0] data;
      logic                     valid;
   } rx_hs_t;

   function automatic int cnt_width(input int word_bits);
      return $clog2(word_bits + 1);
   endfunction

endpackage

// File: rtl/rx_word_assembler_flex_counter.sv
// Wrapping bit counter: counts 0..rollover_val-1 on count_enable, sync clear has priority.
// rollover_flag is combinational and marks the enabled cycle that wraps back to zero.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q;
   logic [NUM_CNT_BITS-1:0] count_d;

   always_comb begin
      rollover_flag = count_enable && !clear
                      && (count_q == (rollover_val - NUM_CNT_BITS'(1)));
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (rollover_flag) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = count_q + NUM_CNT_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out = count_q;

endmodule

// File: rtl/rx_word_assembler.sv
// Deserialises destuffed RX bits into WORD_BITS words held behind a valid/ready register.
// Word visible the cycle after its last bit; a word completing into a blocked holder is dropped and flags overrun.
module rx_word_assembler
   import rx_pkg::*;
#(
   parameter int WORD_BITS = USB_BYTE_BITS,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic                            shift_strobe,
   input  logic                            serial_in,
   input  logic                            ignore_bit,
   input  logic                            clear,
   output logic [WORD_BITS-1:0]            rx_data,
   output logic                            rx_data_valid,
   input  logic                            rx_data_ready,
   output logic [cnt_width(WORD_BITS)-1:0] bit_count,
   output logic                            overrun
);

   localparam int CNT_W = cnt_width(WORD_BITS);

   logic                 accepted;
   logic                 word_done;
   logic                 hold_free;
   logic [WORD_BITS-1:0] shifted;
   logic [WORD_BITS-1:0] sr_q, sr_d;
   logic [WORD_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_data_valid_q, rx_data_valid_d;
   logic                 overrun_q, overrun_d;

   flex_counter #(
      .NUM_CNT_BITS (CNT_W)
   ) u_bit_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .count_enable  (accepted),
      .rollover_val  (CNT_W'(WORD_BITS)),
      .count_out     (bit_count),
      .rollover_flag (word_done)
   );

   always_comb begin
      accepted  = shift_strobe && !ignore_bit && !clear;
      hold_free = !rx_data_valid_q || rx_data_ready;

      if (LSB_FIRST) begin
         shifted = {serial_in, sr_q[WORD_BITS-1:1]};
      end else begin
         shifted = {sr_q[WORD_BITS-2:0], serial_in};
      end

      sr_d = sr_q;
      if (clear) begin
         sr_d = '0;
      end else if (accepted) begin
         sr_d = shifted;
      end

      rx_data_d       = rx_data_q;
      rx_data_valid_d = rx_data_valid_q;
      overrun_d       = overrun_q;

      if (rx_data_valid_q && rx_data_ready) begin
         rx_data_valid_d = 1'b0;
      end
      // A new word may reload on the same edge the old one transfers: no bubble.
      if (word_done) begin
         if (hold_free) begin
            rx_data_d       = shifted;
            rx_data_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
      if (clear) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr_q            <= '0;
         rx_data_q       <= '0;
         rx_data_valid_q <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         sr_q            <= sr_d;
         rx_data_q       <= rx_data_d;
         rx_data_valid_q <= rx_data_valid_d;
         overrun_q       <= overrun_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_data_valid = rx_data_valid_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Directed bench for rx_word_assembler: LSB-first and MSB-first byte instances on one bit stream.
module tb_rx_word_assembler;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       shift_strobe, serial_in, ignore_bit, clear, rx_data_ready;
   logic [7:0] rx_data, rx_data_m;
   logic       rx_data_valid, rx_data_valid_m;
   logic [3:0] bit_count, bit_count_m;
   logic       overrun, overrun_m;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rx_word_assembler #(.WORD_BITS(8), .LSB_FIRST(1'b1)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .shift_strobe  (shift_strobe),
      .serial_in     (serial_in),
      .ignore_bit    (ignore_bit),
      .clear         (clear),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .bit_count     (bit_count),
      .overrun       (overrun)
   );

   rx_word_assembler #(.WORD_BITS(8), .LSB_FIRST(1'b0)) dut_msb (
      .clk           (clk),
      .n_rst         (n_rst),
      .shift_strobe  (shift_strobe),
      .serial_in     (serial_in),
      .ignore_bit    (ignore_bit),
      .clear         (clear),
      .rx_data       (rx_data_m),
      .rx_data_valid (rx_data_valid_m),
      .rx_data_ready (rx_data_ready),
      .bit_count     (bit_count_m),
      .overrun       (overrun_m)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus, applied at a falling edge; returns at the next falling edge.
   task automatic step(input logic stb, input logic b, input logic ign, input logic clr);
      shift_strobe = stb;
      serial_in    = b;
      ignore_bit   = ign;
      clear        = clr;
      @(negedge clk);
      shift_strobe = 1'b0;
      serial_in    = 1'b0;
      ignore_bit   = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) step(1'b1, v[i], 1'b0, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] v);
      send_bits(v, 8);
   endtask

   logic [9:0] st_bits;
   logic [9:0] st_ign;
   logic [7:0] b34;
   logic [3:0] max_cnt;

   initial begin
      n_rst = 1'b0;
      shift_strobe = 1'b0; serial_in = 1'b0; ignore_bit = 1'b0; clear = 1'b0;
      rx_data_ready = 1'b0;
      #1;
      check("rst_data",  32'(rx_data), 32'h0);
      check("rst_valid", 32'(rx_data_valid), 32'h0);
      check("rst_count", 32'(bit_count), 32'h0);
      check("rst_ovr",   32'(overrun), 32'h0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      // Async reset mid-word with a pending word present.
      send_byte(8'hFF);
      check("t1_pend_valid", 32'(rx_data_valid), 32'h1);
      check("t1_pend_data",  32'(rx_data), 32'hFF);
      send_bits(8'hFF, 5);
      check("t1_count5", 32'(bit_count), 32'h5);
      #2 n_rst = 1'b0;
      #1;
      check("t1_async_data",  32'(rx_data), 32'h0);
      check("t1_async_valid", 32'(rx_data_valid), 32'h0);
      check("t1_async_count", 32'(bit_count), 32'h0);
      check("t1_async_ovr",   32'(overrun), 32'h0);
      @(negedge clk);
      n_rst = 1'b1;
      rx_data_ready = 1'b1;
      send_byte(8'h5A);
      check("t1_fresh_data",  32'(rx_data), 32'h5A);
      check("t1_fresh_valid", 32'(rx_data_valid), 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Bit order: stream 1,0,1,0,0,1,0,1 then 1,1,0,0,0,0,0,0.
      send_byte(8'hA5);
      check("t2_lsb_a5",    32'(rx_data), 32'hA5);
      check("t2_msb_a5",    32'(rx_data_m), 32'hA5);
      check("t2_valid_hi",  32'(rx_data_valid), 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("t2_valid_lo",  32'(rx_data_valid), 32'h0);
      send_byte(8'h03);
      check("t2_lsb_03",    32'(rx_data), 32'h03);
      check("t2_msb_c0",    32'(rx_data_m), 32'hC0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Stuffed bits on strobes 4 and 9 must not shift or count.
      st_bits = 10'b0101111100;
      st_ign  = 10'b0100001000;
      max_cnt = '0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, st_bits[i], st_ign[i], 1'b0);
         if (bit_count > max_cnt) max_cnt = bit_count;
         if (i == 3) check("t3_cnt_after_s4", 32'(bit_count), 32'h3);
         if (i == 8) check("t3_cnt_after_s9", 32'(bit_count), 32'h7);
      end
      check("t3_data",    32'(rx_data), 32'h3C);
      check("t3_valid",   32'(rx_data_valid), 32'h1);
      check("t3_cnt_end", 32'(bit_count), 32'h0);
      check("t3_max_cnt", 32'(max_cnt), 32'h7);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back: second word loads on the edge the first transfers.
      rx_data_ready = 1'b0;
      send_byte(8'h12);
      check("t4_first_data", 32'(rx_data), 32'h12);
      b34 = 8'h34;
      send_bits(b34, 7);
      check("t4_hold_data",  32'(rx_data), 32'h12);
      check("t4_hold_valid", 32'(rx_data_valid), 32'h1);
      rx_data_ready = 1'b1;
      step(1'b1, b34[7], 1'b0, 1'b0);
      check("t4_b2b_valid", 32'(rx_data_valid), 32'h1);
      check("t4_b2b_data",  32'(rx_data), 32'h34);
      check("t4_b2b_ovr",   32'(overrun), 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("t4_drained",   32'(rx_data_valid), 32'h0);

      // Overrun: second word dropped, flag sticky across a transfer.
      rx_data_ready = 1'b0;
      send_byte(8'h55);
      check("t5_first", 32'(rx_data), 32'h55);
      check("t5_no_ovr", 32'(overrun), 32'h0);
      send_byte(8'hAA);
      check("t5_kept_data", 32'(rx_data), 32'h55);
      check("t5_ovr_set",   32'(overrun), 32'h1);
      check("t5_valid",     32'(rx_data_valid), 32'h1);
      rx_data_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      rx_data_ready = 1'b0;
      check("t5_xfer_valid", 32'(rx_data_valid), 32'h0);
      check("t5_ovr_sticky", 32'(overrun), 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_ovr_clr",    32'(overrun), 32'h0);

      // clear with a same-cycle strobe, pending word and overrun present.
      send_byte(8'h81);
      send_byte(8'h7E);
      check("t6_ovr_pre", 32'(overrun), 32'h1);
      send_bits(8'hFF, 3);
      check("t6_cnt_pre", 32'(bit_count), 32'h3);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("t6_cnt_clr",   32'(bit_count), 32'h0);
      check("t6_ovr_clr",   32'(overrun), 32'h0);
      check("t6_valid_kept", 32'(rx_data_valid), 32'h1);
      check("t6_data_kept", 32'(rx_data), 32'h81);
      rx_data_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("t6_drained", 32'(rx_data_valid), 32'h0);
      send_bits(8'hC3, 7);
      check("t6_cnt7", 32'(bit_count), 32'h7);
      check("t6_no_early_valid", 32'(rx_data_valid), 32'h0);
      send_bits(8'h80, 1);
      check("t6_fresh_data",  32'(rx_data), 32'h43);
      check("t6_fresh_valid", 32'(rx_data_valid), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
